// File: rtl/rend3r_pkg.sv
// Shared rend3r definitions: pixel/block/frame geometry defaults and the
// bank-occupancy state encoding used by the DRAM block writer.
package rend3r_pkg;

    localparam int PIXEL_BITS_DEF   = 16;
    localparam int BLOCK_BITS_DEF   = 4096;
    localparam int FRAME_WIDTH_DEF  = 1024;
    localparam int FRAME_HEIGHT_DEF = 768;
    localparam int ADDR_BITS_DEF    = 27;

    // Number of full banks waiting for DRAM.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

endpackage

// File: rtl/block_bank.sv
// One block buffer: pixels written by index, start address captured with
// pixel 0, and a full flag raised on completion and cleared on transfer.
module block_bank
    import rend3r_pkg::*;
#(
    parameter int PIXEL_BITS = PIXEL_BITS_DEF,
    parameter int BLOCK_BITS = BLOCK_BITS_DEF,
    parameter int ADDR_BITS  = ADDR_BITS_DEF,
    parameter int IDX_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [PIXEL_BITS-1:0] wr_pixel_i,
    input  logic [ADDR_BITS-1:0]  wr_addr_i,
    input  logic                  set_full_i,
    input  logic                  clr_full_i,
    output logic [BLOCK_BITS-1:0] data_o,
    output logic [ADDR_BITS-1:0]  addr_o,
    output logic                  full_o
);

    logic [BLOCK_BITS-1:0] data_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic                  full_q;

    // NOTE: the pixel store is reset along with the control state because the
    // bus outputs must read zero out of reset; this costs a reset fan-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            addr_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (wr_en_i) begin
                data_q[wr_idx_i*PIXEL_BITS +: PIXEL_BITS] <= wr_pixel_i;
                if (wr_idx_i == '0) addr_q <= wr_addr_i;
            end
            if (set_full_i)      full_q <= 1'b1;
            else if (clr_full_i) full_q <= 1'b0;
        end
    end

    assign data_o = data_q;
    assign addr_o = addr_q;
    assign full_o = full_q;

endmodule

// File: rtl/pixel_block_writer.sv
// Packs a raster pixel stream into fixed-size blocks and hands them to DRAM
// through two ping-pong banks, tracking frame position and SOF realignment.
module pixel_block_writer
    import rend3r_pkg::*;
#(
    parameter int          PIXEL_BITS   = PIXEL_BITS_DEF,
    parameter int          BLOCK_BITS   = BLOCK_BITS_DEF,
    parameter int          FRAME_WIDTH  = FRAME_WIDTH_DEF,
    parameter int          FRAME_HEIGHT = FRAME_HEIGHT_DEF,
    parameter int          ADDR_BITS    = ADDR_BITS_DEF,
    parameter int unsigned BASE_ADDR    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    input  logic [PIXEL_BITS-1:0] pix_data,
    output logic                  pix_ready,
    output logic                  wr_req,
    input  logic                  wr_rdy,
    output logic [ADDR_BITS-1:0]  wr_addr,
    output logic [BLOCK_BITS-1:0] wr_data,
    output logic [10:0]           hcount,
    output logic [10:0]           vcount,
    output logic                  sof_error
);

    localparam int PPB   = BLOCK_BITS / PIXEL_BITS;
    localparam int IDX_W = (PPB > 1) ? $clog2(PPB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PPB - 1);
    localparam logic [10:0] LAST_COL = 11'(FRAME_WIDTH - 1);
    localparam logic [10:0] LAST_ROW = 11'(FRAME_HEIGHT - 1);

    occ_state_e       state_q, state_d;
    logic             fill_bank_q, fill_bank_d;
    logic             drain_bank_q, drain_bank_d;
    logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
    logic [10:0]      hcount_q, hcount_d, vcount_q, vcount_d;
    logic             sof_error_q, sof_error_d;

    logic                  accept, complete, transfer;
    logic [IDX_W-1:0]      wr_idx;
    logic [10:0]           pix_col, pix_row;
    logic [ADDR_BITS-1:0]  pix_addr;
    logic [1:0]            bank_full;
    logic [BLOCK_BITS-1:0] bank_data [2];
    logic [ADDR_BITS-1:0]  bank_addr [2];

    assign pix_ready = enable && (state_q != OCC_TWO);
    assign accept    = pix_valid && pix_ready;

    // An SOF pixel restarts the block and the raster at the frame origin.
    assign wr_idx   = pix_sof ? '0 : fill_idx_q;
    assign pix_col  = pix_sof ? '0 : hcount_q;
    assign pix_row  = pix_sof ? '0 : vcount_q;
    assign complete = accept && (wr_idx == LAST_IDX);
    assign pix_addr = ADDR_BITS'(64'(BASE_ADDR) + 64'(FRAME_WIDTH) * 64'(pix_row) + 64'(pix_col));

    assign wr_req   = bank_full[drain_bank_q];
    assign transfer = wr_req && wr_rdy;
    assign wr_addr  = bank_addr[drain_bank_q];
    assign wr_data  = bank_data[drain_bank_q];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        block_bank #(
            .PIXEL_BITS (PIXEL_BITS),
            .BLOCK_BITS (BLOCK_BITS),
            .ADDR_BITS  (ADDR_BITS),
            .IDX_W      (IDX_W)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en_i    (accept && (fill_bank_q == 1'(b))),
            .wr_idx_i   (wr_idx),
            .wr_pixel_i (pix_data),
            .wr_addr_i  (pix_addr),
            .set_full_i (complete && (fill_bank_q == 1'(b))),
            .clr_full_i (transfer && (drain_bank_q == 1'(b))),
            .data_o     (bank_data[b]),
            .addr_o     (bank_addr[b]),
            .full_o     (bank_full[b])
        );
    end

    // NOTE: every signal assigned here gets its default first, so no path
    // through the block can leave a value held and infer a latch.
    always_comb begin
        state_d      = state_q;
        fill_bank_d  = fill_bank_q ^ complete;
        drain_bank_d = drain_bank_q ^ transfer;
        fill_idx_d   = fill_idx_q;
        hcount_d     = hcount_q;
        vcount_d     = vcount_q;
        sof_error_d  = 1'b0;

        case ({complete, transfer})
            2'b10:   state_d = (state_q == OCC_EMPTY) ? OCC_ONE : OCC_TWO;
            2'b01:   state_d = (state_q == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
            default: state_d = state_q;
        endcase

        if (accept) begin
            fill_idx_d  = complete ? '0 : IDX_W'(wr_idx + 1'b1);
            sof_error_d = pix_sof && ((hcount_q != '0) || (vcount_q != '0) || (fill_idx_q != '0));
            if (pix_col == LAST_COL) begin
                hcount_d = '0;
                vcount_d = (pix_row == LAST_ROW) ? '0 : pix_row + 11'd1;
            end else begin
                hcount_d = pix_col + 11'd1;
                vcount_d = pix_row;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= OCC_EMPTY;
            fill_bank_q  <= 1'b0;
            drain_bank_q <= 1'b0;
            fill_idx_q   <= '0;
            hcount_q     <= '0;
            vcount_q     <= '0;
            sof_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_bank_q  <= fill_bank_d;
            drain_bank_q <= drain_bank_d;
            fill_idx_q   <= fill_idx_d;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            sof_error_q  <= sof_error_d;
        end
    end

    assign hcount    = hcount_q;
    assign vcount    = vcount_q;
    assign sof_error = sof_error_q;

endmodule

// File: tb/tb_pixel_block_writer.sv
// Directed bench for pixel_block_writer with 4-pixel blocks on an 8x2 frame
// based at pixel address 0x100.
module tb_pixel_block_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [15:0] pix_data = '0;
    logic        pix_ready;
    logic        wr_req;
    logic        wr_rdy = 1'b0;
    logic [26:0] wr_addr;
    logic [63:0] wr_data;
    logic [10:0] hcount, vcount;
    logic        sof_error;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pixel_block_writer #(
        .PIXEL_BITS   (16),
        .BLOCK_BITS   (64),
        .FRAME_WIDTH  (8),
        .FRAME_HEIGHT (2),
        .ADDR_BITS    (27),
        .BASE_ADDR    (32'h100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .wr_req    (wr_req),
        .wr_rdy    (wr_rdy),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .hcount    (hcount),
        .vcount    (vcount),
        .sof_error (sof_error)
    );

    typedef struct {
        logic        en, valid, sof;
        logic [15:0] data;
        logic        rdy;
        logic        exp_ready, exp_req, chk_blk;
        logic [26:0] exp_addr;
        logic [63:0] exp_data;
        logic [10:0] exp_h, exp_v;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic en, input logic v, input logic s,
                         input logic [15:0] d, input logic rdy);
        @(negedge clk);
        enable = en; pix_valid = v; pix_sof = s; pix_data = d; wr_rdy = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; wr_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_xfer;
        logic [26:0] exp_addrs[4];
        exp_addrs = '{27'h100, 27'h104, 27'h108, 27'h10C};

        vecs[0] = '{1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 27'h0, 64'h0, 11'd0, 11'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0, 27'h0, 64'h0, 11'd1, 11'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b0, 27'h0, 64'h0, 11'd2, 11'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0, 27'h0, 64'h0, 11'd3, 11'd0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 27'h100,
                    64'h0004_0003_0002_0001, 11'd4, 11'd0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0055, 1'b1, 1'b0, 1'b0, 1'b0, 27'h0, 64'h0, 11'd4, 11'd0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 16'h0005, 1'b1, 1'b1, 1'b0, 1'b0, 27'h0, 64'h0, 11'd4, 11'd0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 27'h0, 64'h0, 11'd5, 11'd0};

        // Reset state.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check("rst_req", wr_req, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        check("rst_h", hcount, 0);
        check("rst_v", vcount, 0);
        check("rst_sof_err", sof_error, 0);
        check("rst_ready", pix_ready, 1);

        // First block, then enable gating of intake.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].en, vecs[i].valid, vecs[i].sof, vecs[i].data, vecs[i].rdy);
            check($sformatf("vec%0d_ready", i), pix_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d_req", i), wr_req, vecs[i].exp_req);
            check($sformatf("vec%0d_h", i), hcount, vecs[i].exp_h);
            check($sformatf("vec%0d_v", i), vcount, vecs[i].exp_v);
            if (vecs[i].chk_blk) begin
                check($sformatf("vec%0d_addr", i), wr_addr, vecs[i].exp_addr);
                check($sformatf("vec%0d_data", i), wr_data, vecs[i].exp_data);
            end
        end

        // Back-pressure: both banks fill, then drain in order.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 16'(i + 1), 1'b0);
            check("bp_ready_fill", pix_ready, 1);
        end
        drive(1'b1, 1'b1, 1'b0, 16'h0009, 1'b0);
        check("bp_ready_full", pix_ready, 0);
        check("bp_req_full", wr_req, 1);
        check("bp_addr0", wr_addr, 27'h100);
        check("bp_data0", wr_data, 64'h0004_0003_0002_0001);
        check("bp_h_full", hcount, 0);
        check("bp_v_full", vcount, 1);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("bp_addr0_hold", wr_addr, 27'h100);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("bp_req1", wr_req, 1);
        check("bp_addr1", wr_addr, 27'h104);
        check("bp_data1", wr_data, 64'h0008_0007_0006_0005);
        check("bp_ready_one", pix_ready, 1);
        for (int i = 9; i <= 12; i++) begin
            drive(1'b1, 1'b1, 1'b0, 16'(i), 1'b1);
            if (i == 9) check("bp_req_drained", wr_req, 0);
            check("bp_ready_resume", pix_ready, 1);
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check("bp_req2", wr_req, 1);
        check("bp_addr2", wr_addr, 27'h108);
        check("bp_data2", wr_data, 64'h000C_000B_000A_0009);

        // Full frame at one pixel per cycle with wr_rdy held high.
        do_reset();
        n_xfer = 0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, c < 16, 1'b0, 16'(c + 1), 1'b1);
            if (c < 16) check("fr_ready", pix_ready, 1);
            if (wr_req) begin
                if (n_xfer < 4) check($sformatf("fr_addr%0d", n_xfer), wr_addr, exp_addrs[n_xfer]);
                n_xfer++;
            end
            if (c == 8) check("fr_data1", wr_data, 64'h0008_0007_0006_0005);
            if (c == 16) begin
                check("fr_h_wrap", hcount, 0);
                check("fr_v_wrap", vcount, 0);
            end
        end
        check("fr_xfer_count", n_xfer, 4);

        // SOF at origin is clean; SOF mid-block realigns and flags an error.
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 16'h0011, 1'b1);
        check("sof_clean", sof_error, 0);
        drive(1'b1, 1'b1, 1'b0, 16'h0022, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 16'hAAAA, 1'b1);
        check("sof_pre", sof_error, 0);
        drive(1'b1, 1'b1, 1'b0, 16'hBBBB, 1'b1);
        check("sof_pulse", sof_error, 1);
        check("sof_h", hcount, 1);
        check("sof_v", vcount, 0);
        drive(1'b1, 1'b1, 1'b0, 16'hCCCC, 1'b1);
        check("sof_pulse_end", sof_error, 0);
        drive(1'b1, 1'b1, 1'b0, 16'hDDDD, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check("sof_req", wr_req, 1);
        check("sof_addr", wr_addr, 27'h100);
        check("sof_data", wr_data, 64'hDDDD_CCCC_BBBB_AAAA);

        // Completion and transfer on the same edge while in ONE.
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            drive(1'b1, 1'b1, 1'b0, 16'(i), 1'b0);
            if (i == 5) begin
                check("same_req_a", wr_req, 1);
                check("same_addr_a", wr_addr, 27'h100);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 16'h0008, 1'b1);
        check("same_ready", pix_ready, 1);
        check("same_addr_xfer", wr_addr, 27'h100);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("same_ready_one", pix_ready, 1);
        check("same_req_b", wr_req, 1);
        check("same_addr_b", wr_addr, 27'h104);
        check("same_data_b", wr_data, 64'h0008_0007_0006_0005);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("same_req_done", wr_req, 0);

        // Reset during a pending request drops it without a transfer.
        do_reset();
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b1, 1'b0, 16'(i), 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check("mrst_req_before", wr_req, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_req_async", wr_req, 0);
        check("mrst_data_async", wr_data, 0);
        wr_rdy = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("mrst_req_rel0", wr_req, 0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("mrst_req_rel1", wr_req, 0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 16'(16'h21 + i), 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check("mrst_req_next", wr_req, 1);
        check("mrst_addr_next", wr_addr, 27'h100);
        check("mrst_data_next", wr_data, 64'h0024_0023_0022_0021);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
